// File: rtl/keypad_scan_debounce_if.sv
// Key-event interface between the keypad scanner (master) and the calculator FSM (slave).
interface keypad_scan_debounce_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (output key_valid, output key_code, output key_held);
  modport slave  (input  key_valid, input  key_code, input  key_held);
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 Pmod keypad column scanner with whole-scan debouncing; emits one key_valid
// strobe per physical press and suppresses rollover, ghosting and auto-repeat.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    row_in,
  output logic [3:0]                    col_out,
  keypad_scan_debounce_if.master        kev
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_e;
  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  res_e          acc_kind_q, acc_kind_d, res_kind_q;
  logic [3:0]    acc_code_q, acc_code_d, res_code_q;
  logic          done_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cand_q;
  logic          valid_q, held_q;
  logic [3:0]    code_q;

  logic       sample;
  logic [3:0] hits;
  logic [2:0] nhit;
  logic [1:0] hit_row;
  logic [3:0] col_code;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b11_11: k = 4'h1;  4'b11_10: k = 4'h2;  4'b11_01: k = 4'h3;  4'b11_00: k = 4'hA;
      4'b10_11: k = 4'h4;  4'b10_10: k = 4'h5;  4'b10_01: k = 4'h6;  4'b10_00: k = 4'hB;
      4'b01_11: k = 4'h7;  4'b01_10: k = 4'h8;  4'b01_01: k = 4'h9;  4'b01_00: k = 4'hC;
      4'b00_11: k = 4'h0;  4'b00_10: k = 4'hF;  4'b00_01: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign sample  = (div_q == DIV_LAST);
  assign col_out = ~(4'b0001 << col_q);

  // Fold the current column's row hits into the running whole-scan result.
  always_comb begin
    hits    = ~row_s2_q;
    nhit    = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    hit_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (hits[i]) hit_row = 2'(i);
    end
    col_code   = key_lut(hit_row, col_q);
    acc_kind_d = acc_kind_q;
    acc_code_d = acc_code_q;
    if (nhit == 3'd1) begin
      if (acc_kind_q == RES_NONE) begin
        acc_kind_d = RES_SINGLE;
        acc_code_d = col_code;
      end else begin
        acc_kind_d = RES_MULTI;
      end
    end else if (nhit > 3'd1) begin
      acc_kind_d = RES_MULTI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      div_q      <= '0;
      col_q      <= '0;
      acc_kind_q <= RES_NONE;
      acc_code_q <= '0;
      res_kind_q <= RES_NONE;
      res_code_q <= '0;
      done_q     <= 1'b0;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
      div_q    <= sample ? '0 : div_q + 1'b1;
      done_q   <= 1'b0;
      if (sample) begin
        col_q <= col_q + 1'b1;
        if (col_q == 2'd3) begin
          res_kind_q <= acc_kind_d;
          res_code_q <= acc_code_d;
          acc_kind_q <= RES_NONE;
          acc_code_q <= '0;
          done_q     <= 1'b1;
        end else begin
          acc_kind_q <= acc_kind_d;
          acc_code_q <= acc_code_d;
        end
      end
    end
  end

  // Debounce FSM; advances only on the cycle after a full scan completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (done_q) begin
        case (state_q)
          IDLE: begin
            if (res_kind_q == RES_SINGLE) begin
              if (DEB_N == CW'(1)) begin
                valid_q <= 1'b1;
                code_q  <= res_code_q;
                held_q  <= 1'b1;
                state_q <= PRESSED;
              end else begin
                state_q <= CAND;
                cand_q  <= res_code_q;
                cnt_q   <= CW'(1);
              end
            end
          end
          CAND: begin
            if (res_kind_q == RES_SINGLE) begin
              if (res_code_q == cand_q) begin
                if (cnt_q + 1'b1 == DEB_N) begin
                  valid_q <= 1'b1;
                  code_q  <= cand_q;
                  held_q  <= 1'b1;
                  state_q <= PRESSED;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end else begin
                cand_q <= res_code_q;
                cnt_q  <= CW'(1);
              end
            end else begin
              state_q <= IDLE;
            end
          end
          PRESSED: begin
            if (res_kind_q == RES_NONE) begin
              if (DEB_N == CW'(1)) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
              end else begin
                state_q <= REL;
                cnt_q   <= CW'(1);
              end
            end
          end
          default: begin
            if (res_kind_q == RES_NONE) begin
              if (cnt_q + 1'b1 == DEB_N) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q <= PRESSED;
            end
          end
        endcase
      end
    end
  end

  assign kev.key_valid = valid_q;
  assign kev.key_code  = code_q;
  assign kev.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=8, DEBOUNCE_SCANS=3 (32-cycle scans).
// Step n counts posedges since reset release; key_valid for a key held from n=0 is seen at n=97.
module tb_keypad_scan_debounce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  int          n;
  int          total, bad;
  int          pulses, doubles, held_cycles;
  logic        prev_v = 1'b0;
  int          p0, h0;

  keypad_scan_debounce_if kif ();

  keypad_scan_debounce #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .kev     (kif)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] kcode(input int r, input int c);
    logic [3:0] k;
    case (r * 4 + c)
      15: k = 4'h1;  14: k = 4'h2;  13: k = 4'h3;  12: k = 4'hA;
      11: k = 4'h4;  10: k = 4'h5;   9: k = 4'h6;   8: k = 4'hB;
       7: k = 4'h7;   6: k = 4'h8;   5: k = 4'h9;   4: k = 4'hC;
       3: k = 4'h0;   2: k = 4'hF;   1: k = 4'hE;   default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Passive keypad: a pressed key shorts its row to its column.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_out[c] && keys[kcode(r, c)]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (kif.key_valid) pulses++;
    if (kif.key_valid && prev_v) doubles++;
    if (kif.key_held) held_cycles++;
    prev_v = kif.key_valid;
  end

  typedef struct {
    int          k;
    logic [3:0]  col;
    logic        valid;
    logic [3:0]  code;
    logic        held;
    logic        apply;
    logic [15:0] keys;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(int k, logic [3:0] col, logic v, logic [3:0] code,
                              logic held, logic apply, logic [15:0] ks);
    vec_t x;
    x.k = k; x.col = col; x.valid = v; x.code = code; x.held = held;
    x.apply = apply; x.keys = ks;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic run_phase(input logic [15:0] mask, input int scans);
    keys = mask;
    repeat (scans * 32) step();
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] col, input logic v,
                               input logic [3:0] code, input logic held);
    check({tag, ".col"},   32'(col_out),      32'(col));
    check({tag, ".valid"}, 32'(kif.key_valid), 32'(v));
    check({tag, ".code"},  32'(kif.key_code),  32'(code));
    check({tag, ".held"},  32'(kif.key_held),  32'(held));
  endtask

  initial begin
    total = 0; bad = 0; n = 0;
    keys  = '0;
    tbl[0]  = mk(  1, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    tbl[1]  = mk(  7, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    tbl[2]  = mk(  8, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    tbl[3]  = mk( 16, 4'b1011, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    tbl[4]  = mk( 24, 4'b0111, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    tbl[5]  = mk( 32, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    tbl[6]  = mk( 96, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    tbl[7]  = mk( 97, 4'b1110, 1'b1, 4'h5, 1'b1, 1'b0, 16'h0);
    tbl[8]  = mk( 98, 4'b1110, 1'b0, 4'h5, 1'b1, 1'b0, 16'h0);
    tbl[9]  = mk(320, 4'b1110, 1'b0, 4'h5, 1'b1, 1'b1, 16'h0);
    tbl[10] = mk(416, 4'b1110, 1'b0, 4'h5, 1'b1, 1'b0, 16'h0);
    tbl[11] = mk(417, 4'b1110, 1'b0, 4'h5, 1'b0, 1'b0, 16'h0);

    // Reset
    rst = 1'b1;
    repeat (3) step();
    check_outputs("reset", 4'b1110, 1'b0, 4'h0, 1'b0);

    // Clean press of '5' from reset release, released after 10 scans
    rst  = 1'b0;
    keys = 16'h1 << 5;
    n    = 0;
    p0   = pulses;
    for (int i = 0; i < 12; i++) begin
      while (n < tbl[i].k) step();
      check_outputs($sformatf("clean@%0d", tbl[i].k), tbl[i].col, tbl[i].valid,
                    tbl[i].code, tbl[i].held);
      if (tbl[i].apply) keys = tbl[i].keys;
    end
    check("clean.pulses", 32'(pulses - p0), 32'd1);

    // Bounce: '7' on alternating scans
    p0 = pulses;
    h0 = held_cycles;
    for (int i = 0; i < 20; i++) begin
      run_phase((i % 2 == 0) ? (16'h1 << 7) : 16'h0, 1);
    end
    check("bounce.pulses", 32'(pulses - p0), 32'd0);
    check("bounce.held_cycles", 32'(held_cycles - h0), 32'd0);

    // Ghosting / rollover
    p0 = pulses;
    run_phase((16'h1 << 1) | (16'h1 << 2), 4);
    check("ghost12.pulses", 32'(pulses - p0), 32'd0);
    check("ghost12.held", 32'(kif.key_held), 32'd0);
    p0 = pulses;
    run_phase(16'h1 << 1, 4);
    check("one.pulses", 32'(pulses - p0), 32'd1);
    check("one.code", 32'(kif.key_code), 32'h1);
    p0 = pulses;
    run_phase((16'h1 << 1) | (16'h1 << 9), 4);
    check("roll19.pulses", 32'(pulses - p0), 32'd0);
    check("roll19.held", 32'(kif.key_held), 32'd1);
    run_phase(16'h0, 3);
    check("rel1.held", 32'(kif.key_held), 32'd0);
    p0 = pulses;
    run_phase(16'h1 << 9, 4);
    check("nine.pulses", 32'(pulses - p0), 32'd1);
    check("nine.code", 32'(kif.key_code), 32'h9);
    run_phase(16'h0, 3);
    check("rel9.held", 32'(kif.key_held), 32'd0);

    // Long hold of 'E'
    p0 = pulses;
    run_phase(16'h1 << 14, 100);
    check("longE.pulses", 32'(pulses - p0), 32'd1);
    check("longE.code", 32'(kif.key_code), 32'hE);
    check("longE.held", 32'(kif.key_held), 32'd1);
    run_phase(16'h0, 3);
    check("relE.held", 32'(kif.key_held), 32'd0);

    // Reset while '3' is held in PRESSED; key is re-accepted as a new press
    run_phase(16'h1 << 3, 4);
    check("pre3.code", 32'(kif.key_code), 32'h3);
    check("pre3.held", 32'(kif.key_held), 32'd1);
    rst = 1'b1;
    repeat (3) step();
    check_outputs("midreset", 4'b1110, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    n   = 0;
    p0  = pulses;
    repeat (96) step();
    check("re3.early_pulses", 32'(pulses - p0), 32'd0);
    check("re3.early_valid", 32'(kif.key_valid), 32'd0);
    step();
    check("re3.valid", 32'(kif.key_valid), 32'd1);
    check("re3.code", 32'(kif.key_code), 32'h3);
    check("re3.held", 32'(kif.key_held), 32'd1);
    step();
    check("re3.pulses", 32'(pulses - p0), 32'd1);

    check("no_double_strobe", 32'(doubles), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Producer side of the key-event interface consumed by the calculator top level.
- Drives the 4x4 Pmod keypad column lines and samples the row lines.
- Debounces the scan result and emits exactly one single-cycle key_valid strobe with a 4-bit hex key_code per physical press.
- Sits between the JB Pmod pins and the calculator FSM, so the consumer needs no lock-out logic.

Parameters:
- SCAN_DIV, 100000: clk cycles per column dwell. 1 ms at 100 MHz. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release. Must be >= 1.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous, active-high reset
- row_in  input  4  keypad rows, active low, externally pulled up. row_in[3]=top row (1 2 3 A), [2]=(4 5 6 B), [1]=(7 8 9 C), [0]=bottom row (0 F E D).
- col_out  output  4  keypad columns, active low, exactly one low at a time. col_out[3]=left column (1 4 7 0), [2]=(2 5 8 F), [1]=(3 6 9 E), [0]=right column (A B C D).
- key_valid  output  1  one-cycle strobe when a debounced press is accepted
- key_code  output  4  hex value of the last accepted key; held until the next accept
- key_held  output  1  high from accept until the debounced release

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; clock is clk.
- Reset values:
  - col_out=4'b1110 (column index 0 active).
  - key_valid=0, key_code=0, key_held=0.
  - FSM=IDLE; dwell counter, column index, debounce counter and scan accumulator all 0.
- row_in passes through a 2-flop synchronizer before any use.
- Scan:
  - Column index c runs 0,1,2,3,0,… and col_out[c] is low.
  - Each column dwells SCAN_DIV cycles.
  - The synchronized rows are sampled on the last dwell cycle, then c advances.
- Scan accumulation:
  - A full scan is 4 dwells, i.e. 4*SCAN_DIV cycles.
  - Its result is NONE (no low row seen), SINGLE(k) (exactly one row/column hit), or MULTI (two or more hits).
  - The result is evaluated once, on the cycle after column 3 is sampled.
- Debounce FSM (advances only on scan-complete cycles):
  - IDLE:
    - SINGLE(k) -> CAND, cand=k, cnt=1. If DEBOUNCE_SCANS=1, accept immediately instead.
    - NONE or MULTI -> stay in IDLE.
  - CAND:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS: accept, go to PRESSED.
    - SINGLE(other) -> restart CAND with the new k, cnt=1.
    - NONE or MULTI -> IDLE.
  - Accept:
    - key_valid=1 for exactly one cycle.
    - key_code<=cand in the same cycle.
    - key_held<=1.
  - PRESSED:
    - NONE -> REL, cnt=1 (if DEBOUNCE_SCANS=1, go straight to IDLE).
    - Any SINGLE or MULTI -> stay. No further strobe; rollover and auto-repeat are suppressed.
  - REL:
    - NONE -> cnt+1. At DEBOUNCE_SCANS: IDLE and key_held<=0.
    - Any key -> back to PRESSED. No strobe, key_held stays 1.
- Latency: key_valid asserts on the scan-complete cycle of the DEBOUNCE_SCANS-th consecutive matching scan, plus registered-output latency of at most 1 cycle. The latency is fixed and documented in the bench.
- key_valid is never high for two consecutive cycles.
- Reset asserted mid-operation takes priority over every other event. After reset, a key still held is treated as a new press.
- Counter widths: sized by $clog2 of the parameters. The dwell counter wraps from SCAN_DIV-1 to 0.

Test Plan:
- All scenarios use SCAN_DIV=8 and DEBOUNCE_SCANS=3, so one scan is 32 cycles. The bench keypad model pulls row r low whenever the matching column is low.
- Reset: hold rst 3 cycles -> col_out=1110, key_valid=0, key_code=0, key_held=0. col_out then rotates 1110,1101,1011,0111, changing every 8 cycles.
- Clean press: hold '5' (row_in[2] × col_out[2]) for 10 scans -> exactly one key_valid pulse, at the end of the 3rd full scan, with key_code=4'h5. key_held stays 1 until 3 empty scans after release.
- Bounce: toggle '7' present/absent on alternating scans for 20 scans -> no key_valid, key_held stays 0.
- Ghosting and rollover:
  - Press '1' and '2' together from IDLE -> no event.
  - Then press '1' alone -> event with code 1.
  - Add '9' while holding '1' -> no event.
  - Release all for 3 scans, then press '9' alone -> event with code 9.
- Long hold: hold 'E' (row_in[0] × col_out[1]) for 100 scans -> exactly one pulse, key_code=4'hE.
- Reset mid-press: assert rst while in PRESSED with '3' still held -> outputs clear and col_out=1110. After 3 full scans, a new pulse with key_code=4'h3.
